mmio_bridge: RTL and testbench
==============================

# mmio_bridge

Parametrised memory-mapped I/O bridge between the CPU's EX/DM-stage data access and up to seven external peripheral channels. Decodes the top three address bits, drives a one-hot request/acknowledge handshake with variable wait states, stalls the pipeline until completion, and reports unmapped or timed-out accesses as a bus error. Region 0 (top bits `000`) stays with internal data memory and is ignored by this block.

## Interface
Parameters:
- DW, 16, CPU data width
- AW, 16, CPU address width; region = addr[AW-1:AW-3]
- PW, 10, peripheral read-data width (PW ≤ DW, zero-extended)
- NCH, 3, number of peripheral channels (1..7)
- TIMEOUT, 15, maximum WAIT cycles before error (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_re  in  1  data read request (held by CPU while stalled)
- cpu_we  in  1  data write request (held while stalled)
- cpu_addr  in  AW  access address
- cpu_wdata  in  DW  store data
- io_hit  out  1  combinational: (cpu_re|cpu_we) & region≠0
- cpu_stall  out  1  freeze pipeline
- cpu_rdata  out  DW  load data, valid in DONE only
- cpu_err  out  1  one-cycle error pulse
- pr_req  out  NCH  one-hot request, held until ack
- pr_we  out  1  write qualifier for pr_req
- pr_addr  out  AW-3  offset within region (registered)
- pr_wdata  out  DW  registered store data
- pr_rdata  in  NCH*PW  per-channel read data, channel k at [k*PW +: PW]
- pr_ack  in  NCH  per-channel completion

## Operation
- States: IDLE, WAIT, DONE, ERR.
- IDLE: if io_hit, latch addr offset, wdata, write flag (cpu_we wins if both set), channel = region-1. Region in 1..NCH → WAIT; region > NCH → ERR. cpu_stall = io_hit (combinational).
- WAIT: pr_req[ch]=1, pr_we=latched flag, cpu_stall=1. pr_ack[ch] → capture zero-extended pr_rdata[ch] (0 for writes), → DONE. Acks on other channels ignored. Wait counter increments each WAIT cycle; reaching TIMEOUT without ack → ERR; ack on the same cycle as timeout wins (→ DONE).
- DONE: cpu_stall=0, cpu_rdata=captured data, → IDLE unconditionally (still-asserted request of the completing instruction is not re-accepted).
- ERR: cpu_stall=0, cpu_err=1, cpu_rdata=0, pr_req=0, → IDLE.
- cpu_rdata = 0 in all states other than DONE.
- Reset (any time, incl. mid-WAIT): state IDLE, pr_req=0, pr_we=0, pr_addr=0, pr_wdata=0, captured data 0, counter 0, cpu_err=0; cpu_stall follows io_hit.

## Timing
- Zero-wait peripheral (ack in first WAIT cycle): cpu_stall high 2 cycles (IDLE accept, WAIT), DONE in cycle 3.
- Each extra wait state adds one stall cycle.
- Unmapped region: 1 stall cycle, cpu_err on cycle 2.
- Timeout: stall = 1 + TIMEOUT cycles, cpu_err on the following cycle.
- Peripheral contract: pr_rdata valid in the cycle pr_ack is high; pr_ack sampled only while pr_req of that channel is high.
- Back-to-back accesses: minimum one IDLE cycle between DONE/ERR and next WAIT.

## Structure
- Package mmio_pkg: state enum (IDLE/WAIT/DONE/ERR), REGION_DM=3'b000 constant, region width constant 3.
- Sub-module mmio_wdog: clearable up-counter of $clog2(TIMEOUT+1) bits with enable and `expired` flag; cleared in IDLE, enabled in WAIT.
- Channel mux for pr_rdata and ack select is inline.

## Test plan
- Read ch0 (addr 0x2004), ack in first WAIT cycle, pr_rdata[0]=10'h3A5 → pr_addr=0x0004, stall 2 cycles, cpu_rdata=0x03A5 in DONE, pr_req=3'b001.
- Write ch2 (addr 0x6010, wdata 0xBEEF), ack after 3 wait states → pr_we=1, pr_wdata=0xBEEF, stall 5 cycles, cpu_rdata=0, no error.
- Access addr 0xE000 with NCH=3 (region 7) → no pr_req ever, stall 1 cycle, cpu_err pulse 1 cycle.
- Read ch1, no ack → stall 16 cycles, cpu_err after, pr_req dropped; ack arriving on exactly cycle 15 of WAIT instead → DONE, no error.
- Assert rst during WAIT on ch1 → pr_req=0 immediately (asynchronously), state IDLE; spurious ack after release ignored.
- Address 0x1FFF with cpu_re → io_hit=0, no stall, no request.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO bridge: FSM state encoding and region decode.
package mmio_pkg;

  localparam int unsigned REGION_W = 3;
  localparam logic [REGION_W-1:0] REGION_DM = 3'b000;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/mmio_wdog.sv
// Wait-state watchdog: clearable up-counter that flags the last permitted WAIT cycle.
module mmio_wdog #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntW'(TIMEOUT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter holds the number of WAIT cycles already elapsed, so TIMEOUT-1 marks the final one.
  assign expired_o = (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/mmio_bridge.sv
// Memory-mapped I/O bridge: decodes the CPU address region and runs a one-hot req/ack
// handshake to a peripheral channel, stalling the pipeline and flagging bus errors.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int unsigned DW      = 16,
  parameter int unsigned AW      = 16,
  parameter int unsigned PW      = 10,
  parameter int unsigned NCH     = 3,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_re_i,
  input  logic              cpu_we_i,
  input  logic [AW-1:0]     cpu_addr_i,
  input  logic [DW-1:0]     cpu_wdata_i,
  output logic              io_hit_o,
  output logic              cpu_stall_o,
  output logic [DW-1:0]     cpu_rdata_o,
  output logic              cpu_err_o,
  output logic [NCH-1:0]    pr_req_o,
  output logic              pr_we_o,
  output logic [AW-4:0]     pr_addr_o,
  output logic [DW-1:0]     pr_wdata_o,
  input  logic [NCH*PW-1:0] pr_rdata_i,
  input  logic [NCH-1:0]    pr_ack_i
);

  state_e              state_q, state_d;
  logic [REGION_W-1:0] ch_q, ch_d;
  logic                we_q, we_d;
  logic [AW-4:0]       addr_q, addr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [DW-1:0]       rdata_q, rdata_d;

  logic [REGION_W-1:0] region;
  logic                ack_sel;
  logic [PW-1:0]       rdata_sel;
  logic                expired;

  assign region   = cpu_addr_i[AW-1 -: REGION_W];
  assign io_hit_o = (cpu_re_i | cpu_we_i) & (region != REGION_DM);

  assign pr_addr_o  = addr_q;
  assign pr_wdata_o = wdata_q;

  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    pr_req_o  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_q == REGION_W'(k)) begin
        ack_sel     = pr_ack_i[k];
        rdata_sel   = pr_rdata_i[k*PW +: PW];
        pr_req_o[k] = (state_q == StWait);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    cpu_stall_o = 1'b0;
    cpu_err_o   = 1'b0;
    cpu_rdata_o = '0;
    pr_we_o     = 1'b0;
    unique case (state_q)
      StIdle: begin
        cpu_stall_o = io_hit_o;
        if (io_hit_o) begin
          ch_d    = region - 1'b1;
          we_d    = cpu_we_i;
          addr_d  = cpu_addr_i[AW-4:0];
          wdata_d = cpu_wdata_i;
          state_d = (32'(region) <= NCH) ? StWait : StErr;
        end
      end
      StWait: begin
        cpu_stall_o = 1'b1;
        pr_we_o     = we_q;
        // A same-cycle ack beats the watchdog.
        if (ack_sel) begin
          rdata_d = we_q ? '0 : DW'(rdata_sel);
          state_d = StDone;
        end else if (expired) begin
          state_d = StErr;
        end
      end
      StDone: begin
        cpu_rdata_o = rdata_q;
        state_d     = StIdle;
      end
      StErr: begin
        cpu_err_o = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ch_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  mmio_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state_q == StIdle),
    .en_i     (state_q == StWait),
    .expired_o(expired)
  );

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed self-checking bench for mmio_bridge with a simple peripheral ack model.
module tb_mmio_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_re, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        io_hit, cpu_stall, cpu_err;
  logic [15:0] cpu_rdata;
  logic [2:0]  pr_req;
  logic        pr_we;
  logic [12:0] pr_addr;
  logic [15:0] pr_wdata;
  logic [29:0] pr_rdata;
  logic [2:0]  pr_ack;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mmio_bridge #(
    .DW(16), .AW(16), .PW(10), .NCH(3), .TIMEOUT(15)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cpu_re_i   (cpu_re),
    .cpu_we_i   (cpu_we),
    .cpu_addr_i (cpu_addr),
    .cpu_wdata_i(cpu_wdata),
    .io_hit_o   (io_hit),
    .cpu_stall_o(cpu_stall),
    .cpu_rdata_o(cpu_rdata),
    .cpu_err_o  (cpu_err),
    .pr_req_o   (pr_req),
    .pr_we_o    (pr_we),
    .pr_addr_o  (pr_addr),
    .pr_wdata_o (pr_wdata),
    .pr_rdata_i (pr_rdata),
    .pr_ack_i   (pr_ack)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One CPU access; ack_at = WAIT cycle (1-based) in which the peripheral acks, 0 = never.
  task automatic run_access(
    input  logic        re,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  int          ack_at,
    input  logic [2:0]  noise,
    output int          stalls,
    output logic        err,
    output logic [2:0]  req,
    output logic        wr,
    output logic [12:0] paddr,
    output logic [15:0] pwdata,
    output logic [15:0] rdata,
    output logic        hit0,
    output logic [2:0]  endreq
  );
    int waits;
    bit done;
    stalls = 0; err = 0; req = 0; wr = 0; paddr = 0; pwdata = 0; rdata = 0;
    hit0 = 0; endreq = 0; waits = 0; done = 0;
    @(posedge clk); #1;
    cpu_re = re; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; pr_ack = noise;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 0) hit0 = io_hit;
      if (pr_req != 3'b000) begin
        req |= pr_req; wr |= pr_we; paddr = pr_addr; pwdata = pr_wdata; waits++;
      end
      if (cpu_stall) stalls++;
      else begin
        done = 1; err = cpu_err; rdata = cpu_rdata; endreq = pr_req;
      end
      pr_ack = noise | ((ack_at != 0 && waits == ack_at) ? pr_req : 3'b000);
    end
    check_eq("access_completes", 32'(done), 32'd1);
    @(posedge clk); #1;
    cpu_re = 0; cpu_we = 0; pr_ack = 0;
    @(negedge clk);
    check_eq("err_one_cycle", 32'(cpu_err), 32'd0);
    check_eq("idle_after_no_stall", 32'(cpu_stall), 32'd0);
  endtask

  int          st;
  logic        er, wr, h0;
  logic [2:0]  rq, erq;
  logic [12:0] pa;
  logic [15:0] pw, rd;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst = 1; cpu_re = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; pr_ack = 0;
    pr_rdata = {10'h155, 10'h2AA, 10'h3A5};
    #12;
    check_eq("rst_req", 32'(pr_req), 32'd0);
    check_eq("rst_we", 32'(pr_we), 32'd0);
    check_eq("rst_addr", 32'(pr_addr), 32'd0);
    check_eq("rst_wdata", 32'(pr_wdata), 32'd0);
    check_eq("rst_err", 32'(cpu_err), 32'd0);
    check_eq("rst_stall", 32'(cpu_stall), 32'd0);
    check_eq("rst_rdata", 32'(cpu_rdata), 32'd0);
    @(posedge clk); #1 rst = 0;

    // Read ch0, zero wait states.
    run_access(1, 0, 16'h2004, 16'h0, 1, 3'b000, st, er, rq, wr, pa, pw, rd, h0, erq);
    check_eq("rd0_hit", 32'(h0), 32'd1);
    check_eq("rd0_stall", 32'(st), 32'd2);
    check_eq("rd0_req", 32'(rq), 32'b001);
    check_eq("rd0_addr", 32'(pa), 32'h0004);
    check_eq("rd0_we", 32'(wr), 32'd0);
    check_eq("rd0_rdata", 32'(rd), 32'h03A5);
    check_eq("rd0_err", 32'(er), 32'd0);

    // Write ch2, three extra wait states.
    run_access(0, 1, 16'h6010, 16'hBEEF, 4, 3'b000, st, er, rq, wr, pa, pw, rd, h0, erq);
    check_eq("wr2_stall", 32'(st), 32'd5);
    check_eq("wr2_req", 32'(rq), 32'b100);
    check_eq("wr2_we", 32'(wr), 32'd1);
    check_eq("wr2_wdata", 32'(pw), 32'hBEEF);
    check_eq("wr2_addr", 32'(pa), 32'h0010);
    check_eq("wr2_rdata", 32'(rd), 32'd0);
    check_eq("wr2_err", 32'(er), 32'd0);

    // Unmapped region 7.
    run_access(1, 0, 16'hE000, 16'h0, 1, 3'b000, st, er, rq, wr, pa, pw, rd, h0, erq);
    check_eq("unm_stall", 32'(st), 32'd1);
    check_eq("unm_req", 32'(rq), 32'd0);
    check_eq("unm_err", 32'(er), 32'd1);
    check_eq("unm_rdata", 32'(rd), 32'd0);

    // Read ch1, no ack on ch1 while ch0/ch2 ack constantly: timeout.
    run_access(1, 0, 16'h4123, 16'h0, 0, 3'b101, st, er, rq, wr, pa, pw, rd, h0, erq);
    check_eq("to_stall", 32'(st), 32'd16);
    check_eq("to_err", 32'(er), 32'd1);
    check_eq("to_req", 32'(rq), 32'b010);
    check_eq("to_req_dropped", 32'(erq), 32'd0);
    check_eq("to_addr", 32'(pa), 32'h0123);
    check_eq("to_rdata", 32'(rd), 32'd0);

    // Ack on the last permitted WAIT cycle wins over the timeout.
    run_access(1, 0, 16'h4123, 16'h0, 15, 3'b000, st, er, rq, wr, pa, pw, rd, h0, erq);
    check_eq("late_stall", 32'(st), 32'd16);
    check_eq("late_err", 32'(er), 32'd0);
    check_eq("late_rdata", 32'(rd), 32'h02AA);

    // Region 0 belongs to data memory.
    run_access(1, 0, 16'h1FFF, 16'h0, 1, 3'b000, st, er, rq, wr, pa, pw, rd, h0, erq);
    check_eq("dm_hit", 32'(h0), 32'd0);
    check_eq("dm_stall", 32'(st), 32'd0);
    check_eq("dm_req", 32'(rq), 32'd0);
    check_eq("dm_err", 32'(er), 32'd0);

    // Read and write together: write wins, read data stays zero.
    run_access(1, 1, 16'h2001, 16'h1234, 2, 3'b000, st, er, rq, wr, pa, pw, rd, h0, erq);
    check_eq("rw_stall", 32'(st), 32'd3);
    check_eq("rw_we", 32'(wr), 32'd1);
    check_eq("rw_wdata", 32'(pw), 32'h1234);
    check_eq("rw_rdata", 32'(rd), 32'd0);

    // Asynchronous reset in the middle of a WAIT on ch1.
    @(posedge clk); #1;
    cpu_re = 1; cpu_addr = 16'h4008;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_pre_req", 32'(pr_req), 32'b010);
    #2 rst = 1;
    #1;
    check_eq("rst_mid_req", 32'(pr_req), 32'd0);
    check_eq("rst_mid_addr", 32'(pr_addr), 32'd0);
    check_eq("rst_mid_stall", 32'(cpu_stall), 32'd1);
    check_eq("rst_mid_err", 32'(cpu_err), 32'd0);
    @(posedge clk); #1;
    cpu_re = 0; pr_ack = 3'b010; rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("spur_req", 32'(pr_req), 32'd0);
      check_eq("spur_stall", 32'(cpu_stall), 32'd0);
      check_eq("spur_rdata", 32'(cpu_rdata), 32'd0);
      check_eq("spur_err", 32'(cpu_err), 32'd0);
    end
    pr_ack = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
